voice_allocator: RTL and testbench

//  Parametrised polyphonic voice allocator; successor to the fixed-count note dispatcher.

---
 rtl/voice_allocator_pkg.sv | 36 +++
 rtl/voice_allocator_picker.sv | 84 ++++++++
 rtl/voice_allocator.sv | 225 ++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/voice_allocator_pkg.sv
// Shared MIDI constants, voice/FSM enums and the latched message payload.
package voice_allocator_pkg;

  localparam int unsigned NOTE_W   = 7;
  localparam int unsigned CHAN_W   = 4;
  localparam int unsigned VSTATE_W = 2;

  localparam logic [3:0] STATUS_NOTE_OFF = 4'h8;
  localparam logic [3:0] STATUS_NOTE_ON  = 4'h9;
  localparam logic [3:0] STATUS_CC       = 4'hB;

  localparam logic [6:0] CC_SUSTAIN        = 7'd64;
  localparam logic [6:0] CC_ALL_OFF        = 7'd123;
  localparam logic [6:0] SUSTAIN_THRESHOLD = 7'd64;

  typedef enum logic [VSTATE_W-1:0] {
    V_IDLE      = 2'd0,
    V_HELD      = 2'd1,
    V_SUSTAINED = 2'd2
  } voice_state_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SEARCH   = 3'd1,
    S_EMIT_OFF = 3'd2,
    S_EMIT_ON  = 3'd3,
    S_SWEEP    = 3'd4
  } alloc_state_t;

  typedef struct packed {
    logic [7:0]        status;
    logic [NOTE_W-1:0] data1;
    logic [NOTE_W-1:0] data2;
  } midi_msg_t;

endpackage

// File: rtl/voice_allocator_picker.sv
// Combinational voice choice for a note-on: retrigger, free voice, then oldest steal.
module voice_allocator_picker
  import voice_allocator_pkg::*;
#(
  parameter int unsigned VOICE_COUNT  = 8,
  parameter int unsigned AGE_WIDTH    = 8,
  parameter int unsigned IDX_W        = 3,
  parameter bit          STEAL_ENABLE = 1'b1
) (
  input  logic [VOICE_COUNT*VSTATE_W-1:0]  states,
  input  logic [VOICE_COUNT*AGE_WIDTH-1:0] ages,
  input  logic [VOICE_COUNT-1:0]           match,
  output logic [IDX_W-1:0]                 pick_idx,
  output logic                             pick_valid,
  output logic                             pick_steal
);

  voice_state_t          st;
  logic [AGE_WIDTH-1:0]  a;
  logic                  retrig_hit, idle_hit, sus_hit, held_hit;
  logic [IDX_W-1:0]      retrig_idx, idle_idx, sus_idx, held_idx;
  logic [AGE_WIDTH-1:0]  sus_age, held_age;

  // Scan voices: first match, first idle, and oldest (strictly greater age keeps lowest index on ties)
  always_comb begin
    st         = V_IDLE;
    a          = '0;
    retrig_hit = 1'b0;
    idle_hit   = 1'b0;
    sus_hit    = 1'b0;
    held_hit   = 1'b0;
    retrig_idx = '0;
    idle_idx   = '0;
    sus_idx    = '0;
    held_idx   = '0;
    sus_age    = '0;
    held_age   = '0;
    for (int i = 0; i < VOICE_COUNT; i++) begin
      st = voice_state_t'(states[i*VSTATE_W +: VSTATE_W]);
      a  = ages[i*AGE_WIDTH +: AGE_WIDTH];
      if (match[i] && (st != V_IDLE) && !retrig_hit) begin
        retrig_hit = 1'b1;
        retrig_idx = IDX_W'(i);
      end
      if ((st == V_IDLE) && !idle_hit) begin
        idle_hit = 1'b1;
        idle_idx = IDX_W'(i);
      end
      if ((st == V_SUSTAINED) && (!sus_hit || (a > sus_age))) begin
        sus_hit = 1'b1;
        sus_idx = IDX_W'(i);
        sus_age = a;
      end
      if ((st == V_HELD) && (!held_hit || (a > held_age))) begin
        held_hit = 1'b1;
        held_idx = IDX_W'(i);
        held_age = a;
      end
    end
  end

  // Priority selection between the candidate classes
  always_comb begin
    pick_valid = 1'b0;
    pick_steal = 1'b0;
    pick_idx   = '0;
    if (retrig_hit) begin
      pick_valid = 1'b1;
      pick_idx   = retrig_idx;
    end else if (idle_hit) begin
      pick_valid = 1'b1;
      pick_idx   = idle_idx;
    end else if (STEAL_ENABLE && sus_hit) begin
      pick_valid = 1'b1;
      pick_steal = 1'b1;
      pick_idx   = sus_idx;
    end else if (STEAL_ENABLE && held_hit) begin
      pick_valid = 1'b1;
      pick_steal = 1'b1;
      pick_idx   = held_idx;
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: channel filter, note-on/off, sustain pedal and all-notes-off.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int unsigned VOICE_COUNT  = 8,
  parameter logic [15:0] CHANNEL_MASK = 16'hFFFF,
  parameter bit          STEAL_ENABLE = 1'b1,
  parameter int unsigned AGE_WIDTH    = 8
) (
  input  logic                          clock_50_000_000,
  input  logic                          reset,
  input  logic                          msg_valid,
  output logic                          msg_ready,
  input  logic [7:0]                    msg_status,
  input  logic [NOTE_W-1:0]             msg_data1,
  input  logic [NOTE_W-1:0]             msg_data2,
  output logic [VOICE_COUNT-1:0]        voice_strobe,
  output logic [VOICE_COUNT-1:0]        voice_gate,
  output logic [VOICE_COUNT*NOTE_W-1:0] voice_note,
  output logic [VOICE_COUNT*NOTE_W-1:0] voice_velocity,
  output logic [VOICE_COUNT*CHAN_W-1:0] voice_channel,
  output logic                          note_dropped
);

  localparam int unsigned IDX_W = (VOICE_COUNT > 1) ? $clog2(VOICE_COUNT) : 1;

  alloc_state_t          state, next_state;
  midi_msg_t             msg;
  logic                  sustain;
  logic                  pend_on;
  logic                  sweep_all;
  logic [IDX_W-1:0]      tgt, sweep_idx;
  voice_state_t          vstate [VOICE_COUNT];
  logic [AGE_WIDTH-1:0]  age    [VOICE_COUNT];

  logic [CHAN_W-1:0]     chan_c;
  logic                  accept_c, chan_ok_c;
  logic                  is_on_c, is_off_c, is_sus_c, is_all_c;
  logic [VOICE_COUNT-1:0] match_c;
  logic                  off_hit_c;
  logic [IDX_W-1:0]      off_idx_c;
  logic [VOICE_COUNT*VSTATE_W-1:0]  states_flat_c;
  logic [VOICE_COUNT*AGE_WIDTH-1:0] ages_flat_c;
  logic [IDX_W-1:0]      pick_idx_c;
  logic                  pick_valid_c, pick_steal_c;

  assign accept_c = msg_valid && msg_ready;

  // Classify the latched message
  always_comb begin
    chan_c    = msg.status[3:0];
    chan_ok_c = CHANNEL_MASK[chan_c];
    is_on_c   = chan_ok_c && (msg.status[7:4] == STATUS_NOTE_ON) && (msg.data2 != '0);
    is_off_c  = chan_ok_c && ((msg.status[7:4] == STATUS_NOTE_OFF) ||
                              ((msg.status[7:4] == STATUS_NOTE_ON) && (msg.data2 == '0)));
    is_sus_c  = chan_ok_c && (msg.status[7:4] == STATUS_CC) && (msg.data1 == CC_SUSTAIN);
    is_all_c  = chan_ok_c && (msg.status[7:4] == STATUS_CC) && (msg.data1 == CC_ALL_OFF);
  end

  // Per-voice note/channel match, flattened picker inputs, lowest HELD match for note-off
  always_comb begin
    match_c       = '0;
    states_flat_c = '0;
    ages_flat_c   = '0;
    off_hit_c     = 1'b0;
    off_idx_c     = '0;
    for (int i = 0; i < VOICE_COUNT; i++) begin
      match_c[i] = (vstate[i] != V_IDLE) &&
                   (voice_note[i*NOTE_W +: NOTE_W] == msg.data1) &&
                   (voice_channel[i*CHAN_W +: CHAN_W] == chan_c);
      states_flat_c[i*VSTATE_W +: VSTATE_W] = vstate[i];
      ages_flat_c[i*AGE_WIDTH +: AGE_WIDTH] = age[i];
      if (match_c[i] && (vstate[i] == V_HELD) && !off_hit_c) begin
        off_hit_c = 1'b1;
        off_idx_c = IDX_W'(i);
      end
    end
  end

  voice_allocator_picker #(
    .VOICE_COUNT  (VOICE_COUNT),
    .AGE_WIDTH    (AGE_WIDTH),
    .IDX_W        (IDX_W),
    .STEAL_ENABLE (STEAL_ENABLE)
  ) u_picker (
    .states     (states_flat_c),
    .ages       (ages_flat_c),
    .match      (match_c),
    .pick_idx   (pick_idx_c),
    .pick_valid (pick_valid_c),
    .pick_steal (pick_steal_c)
  );

  // FSM state register
  always_ff @(posedge clock_50_000_000) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (accept_c) next_state = S_SEARCH;
      S_SEARCH: begin
        next_state = S_IDLE;
        if (is_on_c) begin
          if (pick_valid_c) next_state = pick_steal_c ? S_EMIT_OFF : S_EMIT_ON;
        end else if (is_off_c) begin
          if (off_hit_c && !sustain) next_state = S_EMIT_OFF;
        end else if (is_sus_c) begin
          if (msg.data2 < SUSTAIN_THRESHOLD) next_state = S_SWEEP;
        end else if (is_all_c) begin
          next_state = S_SWEEP;
        end
      end
      S_EMIT_OFF: next_state = pend_on ? S_EMIT_ON : S_IDLE;
      S_EMIT_ON:  next_state = S_IDLE;
      S_SWEEP:    if (sweep_idx == IDX_W'(VOICE_COUNT - 1)) next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Datapath: message latch, voice table, registered outputs
  always_ff @(posedge clock_50_000_000) begin
    if (reset) begin
      msg_ready      <= 1'b1;
      voice_strobe   <= '0;
      voice_gate     <= '0;
      voice_note     <= '0;
      voice_velocity <= '0;
      voice_channel  <= '0;
      note_dropped   <= 1'b0;
      msg            <= '0;
      sustain        <= 1'b0;
      pend_on        <= 1'b0;
      sweep_all      <= 1'b0;
      tgt            <= '0;
      sweep_idx      <= '0;
      for (int i = 0; i < VOICE_COUNT; i++) begin
        vstate[i] <= V_IDLE;
        age[i]    <= '0;
      end
    end else begin
      voice_strobe <= '0;
      note_dropped <= 1'b0;
      msg_ready    <= (next_state == S_IDLE);
      case (state)
        S_IDLE: begin
          if (accept_c) begin
            msg.status <= msg_status;
            msg.data1  <= msg_data1;
            msg.data2  <= msg_data2;
          end
        end
        S_SEARCH: begin
          if (is_on_c) begin
            if (pick_valid_c) begin
              tgt     <= pick_idx_c;
              pend_on <= 1'b1;
            end else begin
              note_dropped <= 1'b1;
            end
          end else if (is_off_c) begin
            if (off_hit_c) begin
              tgt     <= off_idx_c;
              pend_on <= 1'b0;
              if (sustain) begin
                for (int i = 0; i < VOICE_COUNT; i++)
                  if (IDX_W'(i) == off_idx_c) vstate[i] <= V_SUSTAINED;
              end
            end
          end else if (is_sus_c) begin
            sustain   <= (msg.data2 >= SUSTAIN_THRESHOLD);
            sweep_idx <= '0;
            sweep_all <= 1'b0;
          end else if (is_all_c) begin
            sustain   <= 1'b0;
            sweep_idx <= '0;
            sweep_all <= 1'b1;
          end
        end
        S_EMIT_OFF: begin
          for (int i = 0; i < VOICE_COUNT; i++) begin
            if (IDX_W'(i) == tgt) begin
              vstate[i]                           <= V_IDLE;
              voice_gate[i]                       <= 1'b0;
              voice_velocity[i*NOTE_W +: NOTE_W]  <= '0;
              voice_strobe[i]                     <= 1'b1;
            end
          end
        end
        S_EMIT_ON: begin
          for (int i = 0; i < VOICE_COUNT; i++) begin
            if (IDX_W'(i) == tgt) begin
              vstate[i]                           <= V_HELD;
              age[i]                              <= '0;
              voice_gate[i]                       <= 1'b1;
              voice_note[i*NOTE_W +: NOTE_W]      <= msg.data1;
              voice_velocity[i*NOTE_W +: NOTE_W]  <= msg.data2;
              voice_channel[i*CHAN_W +: CHAN_W]   <= chan_c;
              voice_strobe[i]                     <= 1'b1;
            end else if ((vstate[i] != V_IDLE) && (age[i] != {AGE_WIDTH{1'b1}})) begin
              age[i] <= age[i] + AGE_WIDTH'(1);
            end
          end
        end
        S_SWEEP: begin
          for (int i = 0; i < VOICE_COUNT; i++) begin
            if ((IDX_W'(i) == sweep_idx) &&
                (sweep_all ? (vstate[i] != V_IDLE) : (vstate[i] == V_SUSTAINED))) begin
              vstate[i]                           <= V_IDLE;
              voice_gate[i]                       <= 1'b0;
              voice_velocity[i*NOTE_W +: NOTE_W]  <= '0;
              voice_strobe[i]                     <= 1'b1;
            end
          end
          sweep_idx <= sweep_idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: allocation, steal/drop, pedal, filter, all-off, reset.
module tb_voice_allocator;

  localparam int unsigned VC = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid, valid_ns;
  logic [7:0]  status;
  logic [6:0]  d1, d2;

  logic          ready, dropped;
  logic [VC-1:0] strobe, gate;
  logic [VC*7-1:0] note, vel;
  logic [VC*4-1:0] chan;

  logic          ready_ns, dropped_ns;
  logic [VC-1:0] strobe_ns, gate_ns;
  logic [VC*7-1:0] note_ns, vel_ns;
  logic [VC*4-1:0] chan_ns;

  int total = 0;
  int bad   = 0;
  int cnt;
  int multi;

  voice_allocator #(
    .VOICE_COUNT(VC), .CHANNEL_MASK(16'h0001), .STEAL_ENABLE(1'b1), .AGE_WIDTH(8)
  ) dut (
    .clock_50_000_000(clk), .reset(reset),
    .msg_valid(valid), .msg_ready(ready),
    .msg_status(status), .msg_data1(d1), .msg_data2(d2),
    .voice_strobe(strobe), .voice_gate(gate), .voice_note(note),
    .voice_velocity(vel), .voice_channel(chan), .note_dropped(dropped)
  );

  voice_allocator #(
    .VOICE_COUNT(VC), .CHANNEL_MASK(16'hFFFF), .STEAL_ENABLE(1'b0), .AGE_WIDTH(8)
  ) dut_ns (
    .clock_50_000_000(clk), .reset(reset),
    .msg_valid(valid_ns), .msg_ready(ready_ns),
    .msg_status(status), .msg_data1(d1), .msg_data2(d2),
    .voice_strobe(strobe_ns), .voice_gate(gate_ns), .voice_note(note_ns),
    .voice_velocity(vel_ns), .voice_channel(chan_ns), .note_dropped(dropped_ns)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one message; returns 1 time unit after the accept edge
  task automatic send(input bit ns, input logic [7:0] s, input logic [6:0] a, input logic [6:0] b);
    for (int k = 0; k < 50; k++) begin
      if ((ns ? ready_ns : ready) === 1'b1) break;
      step();
    end
    chk("ready_before_send", 32'(ns ? ready_ns : ready), 32'd1);
    status = s; d1 = a; d2 = b;
    if (ns) valid_ns = 1'b1; else valid = 1'b1;
    step();
    valid = 1'b0; valid_ns = 1'b0;
  endtask

  // Note-on on a free voice; returns just after the emit edge (T+2)
  task automatic note_on(input bit ns, input logic [6:0] n, input logic [6:0] v);
    send(ns, 8'h90, n, v);
    step();
    step();
  endtask

  initial begin
    reset = 1'b1; valid = 1'b0; valid_ns = 1'b0; status = '0; d1 = '0; d2 = '0;
    repeat (3) step();
    reset = 1'b0;
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_strobe", 32'(strobe), 32'd0);
    chk("rst_gate", 32'(gate), 32'd0);
    chk("rst_note", 32'(note), 32'd0);
    chk("rst_dropped", 32'(dropped), 32'd0);

    // First note-on lands on voice 0 at T+2
    send(0, 8'h90, 7'd60, 7'd100);
    chk("t1_ready_low", 32'(ready), 32'd0);
    step();
    chk("t1_no_strobe_t1", 32'(strobe), 32'd0);
    step();
    chk("t1_strobe", 32'(strobe), 32'h1);
    chk("t1_gate", 32'(gate), 32'h1);
    chk("t1_note", 32'(note[6:0]), 32'd60);
    chk("t1_vel", 32'(vel[6:0]), 32'd100);
    chk("t1_chan", 32'(chan[3:0]), 32'd0);
    chk("t1_ready_back", 32'(ready), 32'd1);
    step();
    chk("t1_strobe_pulse", 32'(strobe), 32'd0);

    // Retrigger same note: same voice, new velocity
    note_on(0, 7'd60, 7'd90);
    chk("t4_strobe", 32'(strobe), 32'h1);
    chk("t4_gate", 32'(gate), 32'h1);
    chk("t4_vel", 32'(vel[6:0]), 32'd90);

    // Fill remaining voices
    note_on(0, 7'd61, 7'd10);
    chk("t2_fill1", 32'(strobe), 32'h2);
    note_on(0, 7'd62, 7'd20);
    chk("t2_fill2", 32'(strobe), 32'h4);
    note_on(0, 7'd63, 7'd30);
    chk("t2_fill3", 32'(strobe), 32'h8);
    chk("t2_full_gate", 32'(gate), 32'hF);

    // Fifth note steals voice 0 (oldest, age 3): off then on
    send(0, 8'h90, 7'd65, 7'd77);
    step();
    chk("t2_steal_t1", 32'(strobe), 32'd0);
    step();
    chk("t2_off_strobe", 32'(strobe), 32'h1);
    chk("t2_off_gate", 32'(gate), 32'hE);
    chk("t2_off_vel", 32'(vel[6:0]), 32'd0);
    step();
    chk("t2_on_strobe", 32'(strobe), 32'h1);
    chk("t2_on_gate", 32'(gate), 32'hF);
    chk("t2_on_note", 32'(note[6:0]), 32'd65);
    chk("t2_on_vel", 32'(vel[6:0]), 32'd77);
    chk("t2_v1_note", 32'(note[13:7]), 32'd61);
    chk("t2_no_drop", 32'(dropped), 32'd0);

    // Steal disabled: fifth note dropped, voices untouched
    for (int i = 0; i < 4; i++) note_on(1, 7'(40 + i), 7'd50);
    chk("ns_full_gate", 32'(gate_ns), 32'hF);
    send(1, 8'h90, 7'd44, 7'd50);
    step();
    chk("ns_dropped", 32'(dropped_ns), 32'd1);
    chk("ns_gate_kept", 32'(gate_ns), 32'hF);
    step();
    chk("ns_drop_pulse", 32'(dropped_ns), 32'd0);
    chk("ns_no_strobe", 32'(strobe_ns), 32'd0);

    // All-notes-off with 4 voices: one strobe per sweep cycle
    send(0, 8'hB0, 7'd123, 7'd0);
    step();
    step();
    chk("ao4_s0", 32'(strobe), 32'h1);
    step();
    chk("ao4_s1", 32'(strobe), 32'h2);
    step();
    chk("ao4_s2", 32'(strobe), 32'h4);
    chk("ao4_ready_low", 32'(ready), 32'd0);
    step();
    chk("ao4_s3", 32'(strobe), 32'h8);
    chk("ao4_gate", 32'(gate), 32'd0);
    chk("ao4_ready_back", 32'(ready), 32'd1);

    // Sustain pedal holds a released note until pedal up
    send(0, 8'hB0, 7'd64, 7'd127);
    step();
    chk("ped_on_ready", 32'(ready), 32'd1);
    chk("ped_on_strobe", 32'(strobe), 32'd0);
    note_on(0, 7'd64, 7'd100);
    chk("ped_note_strobe", 32'(strobe), 32'h1);
    send(0, 8'h80, 7'd64, 7'd0);
    step();
    chk("ped_off_strobe_t1", 32'(strobe), 32'd0);
    step();
    chk("ped_off_strobe_t2", 32'(strobe), 32'd0);
    chk("ped_gate_held", 32'(gate), 32'h1);
    send(0, 8'hB0, 7'd64, 7'd0);
    step();
    step();
    chk("ped_up_strobe", 32'(strobe), 32'h1);
    chk("ped_up_gate", 32'(gate), 32'd0);
    chk("ped_up_vel", 32'(vel[6:0]), 32'd0);

    // Channel 3 masked off: ignored, ready returns next cycle
    send(0, 8'h93, 7'd50, 7'd50);
    chk("mask_ready_low", 32'(ready), 32'd0);
    step();
    chk("mask_ready_back", 32'(ready), 32'd1);
    chk("mask_gate", 32'(gate), 32'd0);
    chk("mask_strobe", 32'(strobe), 32'd0);

    // All-notes-off with 3 active voices
    note_on(0, 7'd70, 7'd1);
    note_on(0, 7'd71, 7'd2);
    note_on(0, 7'd72, 7'd3);
    chk("ao3_gate_before", 32'(gate), 32'h7);
    send(0, 8'hB0, 7'd123, 7'd0);
    cnt = 0;
    multi = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      cnt += $countones(strobe);
      if ($countones(strobe) > 1) multi++;
    end
    chk("ao3_strobes", 32'(cnt), 32'd3);
    chk("ao3_onehot", 32'(multi), 32'd0);
    chk("ao3_gate_after", 32'(gate), 32'd0);
    chk("ao3_ready", 32'(ready), 32'd1);

    // Reset asserted mid-sweep
    note_on(0, 7'd80, 7'd5);
    note_on(0, 7'd81, 7'd6);
    send(0, 8'hB0, 7'd123, 7'd0);
    step();
    step();
    chk("rs_first_off", 32'(strobe), 32'h1);
    reset = 1'b1;
    step();
    chk("rs_gate", 32'(gate), 32'd0);
    chk("rs_strobe", 32'(strobe), 32'd0);
    chk("rs_ready", 32'(ready), 32'd1);
    reset = 1'b0;
    step();
    chk("rs_quiet", 32'(strobe), 32'd0);
    note_on(0, 7'd60, 7'd100);
    chk("rs_realloc_strobe", 32'(strobe), 32'h1);
    chk("rs_realloc_gate", 32'(gate), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
